// File: rtl/wb_prog_loader.sv
// wb_prog_loader
//   Wishbone slave that lets the management CPU stream program words into the
//   subservient core. Each DATA write queues {ADDR, data} in a small FIFO. A
//   debug master replays the queue as single write cycles. The core is held in
//   reset while HOLD is set or while any write is still queued or in flight.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, async active-high reset
//   wbs_*                   management Wishbone slave (16-byte window at BASE_ADDR)
//   dbg_stb_o/adr_o/dat_o   debug bus write master (cyc == stb)
//   dbg_ack_i               debug bus acknowledge
//   core_rst_o              core reset, active-high
//
// Register map (word offset)
//   0 CTRL   [0] HOLD (reset 1)
//   1 ADDR   load pointer, bits [1:0] read as 0
//   2 DATA   write queues {ADDR, data} and then ADDR += 4; reads return 0
//   3 STATUS [7:0] level, [8] busy, [9] err (sticky, write 1 to bit 9 to clear)
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dbg_stb_o,
    output logic [31:0] dbg_adr_o,
    output logic [31:0] dbg_dat_o,
    input  logic        dbg_ack_i,
    output logic        core_rst_o
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       TMO     = 8'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // Byte selects are ignored and the low address bits are not decoded.
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // ---------------- state ----------------
    logic [31:0]      fifo_adr_q [FIFO_DEPTH];
    logic [31:0]      fifo_dat_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hold_q, hold_d;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdat_q, rdat_d;
    state_t           state_q, state_d;
    logic             stb_q, stb_d;
    logic [31:0]      dadr_q, dadr_d;
    logic [31:0]      ddat_q, ddat_d;
    logic [7:0]       timer_q, timer_d;

    logic full, empty, busy;
    logic req, data_wr, accept, push, pop, abort, err_clr;
    logic [1:0] off;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign busy  = !empty || (state_q == S_WAIT);
    assign off   = wbs_adr_i[3:2];

    // ---------------- mgmt slave ----------------
    assign req     = wbs_cyc_i && wbs_stb_i && !ack_q &&
                     (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign data_wr = wbs_we_i && (off == 2'd2);
    // A DATA write into a full FIFO simply stays pending until a pop frees a slot.
    assign accept  = req && !(data_wr && full);
    assign push    = accept && data_wr;

    always_comb begin
        ack_d   = 1'b0;
        rdat_d  = '0;
        hold_d  = hold_q;
        addr_d  = addr_q;
        err_clr = 1'b0;
        if (accept) begin
            ack_d = 1'b1;
            if (wbs_we_i) begin
                case (off)
                    2'd0:    hold_d  = wbs_dat_i[0];
                    2'd1:    addr_d  = {wbs_dat_i[31:2], 2'b00};
                    2'd2:    addr_d  = addr_q + 32'd4;
                    default: err_clr = wbs_dat_i[9];
                endcase
            end else begin
                case (off)
                    2'd0:    rdat_d = {31'd0, hold_q};
                    2'd1:    rdat_d = addr_q;
                    2'd2:    rdat_d = '0;
                    default: rdat_d = {22'd0, err_q, busy, 8'(count_q)};
                endcase
            end
        end
    end

    // ---------------- debug master FSM ----------------
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        dadr_d  = dadr_q;
        ddat_d  = ddat_q;
        timer_d = timer_q;
        pop     = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Entry stays in the FIFO (and counts toward level) until it retires.
                if (!empty) begin
                    dadr_d  = fifo_adr_q[rd_ptr_q];
                    ddat_d  = fifo_dat_q[rd_ptr_q];
                    stb_d   = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (dbg_ack_i) begin
                    pop     = 1'b1;
                    stb_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (timer_q == TMO) begin
                    pop     = 1'b1;
                    abort   = 1'b1;
                    stb_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
    end

    // A timeout in the same cycle as a clear wins, so no error is lost.
    always_comb begin
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (abort)   err_d = 1'b1;
    end

    // ---------------- registers ----------------
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_adr_q[wr_ptr_q] <= addr_q;
            fifo_dat_q[wr_ptr_q] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= 1'b1;
            addr_q   <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            state_q  <= S_IDLE;
            stb_q    <= 1'b0;
            dadr_q   <= '0;
            ddat_q   <= '0;
            timer_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            state_q <= state_d;
            stb_q   <= stb_d;
            dadr_q  <= dadr_d;
            ddat_q  <= ddat_d;
            timer_q <= timer_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdat_q;
    assign dbg_stb_o  = stb_q;
    assign dbg_adr_o  = dadr_q;
    assign dbg_dat_o  = ddat_q;
    assign core_rst_o = hold_q || busy;

endmodule
